fetch_aligner: RTL and testbench
================================

// Module: fetch_aligner
// PURPOSE
//  Sequences the raw 32-bit fetch stream into whole instructions for the decode/parse stage.
//  Handles mixed 16-bit (RVC) and 32-bit encodings, including 32-bit instructions that straddle
//  fetch words and halfword-aligned branch targets.
//  Sits between the fetch port and the instruction parser.
//  Emits exactly one instruction per output handshake, with its PC and byte size.
// PARAMETERS
//  PC_W      32            width of PC values
//  RESET_PC  32'h0000_0000 PC of the first instruction after reset; bit 0 must be 0
// PORTS
//  clk         in   1     single clock, all state on rising edge
//  rst         in   1     asynchronous, active-high reset
//  fetch_valid in   1     fetch_data holds a 32-bit word-aligned fetch word
//  fetch_ready out  1     aligner can take a word this cycle
//  fetch_data  in   32    fetch word; halfword 0 = [15:0] (lower address)
//  flush       in   1     redirect: discard all buffered/in-flight data
//  flush_pc    in   PC_W  new PC on flush (bit 0 ignored)
//  instr_valid out  1     instr_* hold a complete instruction
//  instr_ready in   1     downstream accepts instruction
//  instr_data  out  32    instruction; compressed -> {16'h0, hw}
//  instr_size  out  3     byte size: 2 or 4
//  instr_pc    out  PC_W  address of instr_data
// BEHAVIOUR
//  Storage
//   - 4-halfword shift buffer hw[0..3]; count cnt 0..4; hw[0] is the oldest halfword.
//   - fetch_ready = (cnt <= 2) && !flush; combinational from state only, no path from instr_ready.
//   - Fetch handshake (fetch_valid && fetch_ready): append two halfwords at hw[cnt-consumed].
//     In SKIP state, append only fetch_data[31:16] (1 halfword).
//  Output decode
//   - hw[0][1:0] != 2'b11 -> compressed.
//   - instr_valid = (cnt >= 1 && compressed) || (cnt >= 2).
//   - instr_size = compressed ? 2 : 4.
//   - instr_data = compressed ? {16'h0, hw[0]} : {hw[1], hw[0]}.
//   - All outputs are combinational from registers. Outputs are stable while valid && !ready.
//   - Encodings with [4:2]==3'b111 (>32-bit) are treated as 32-bit; no error flag.
//  Consumption
//   - Output handshake consumes size/2 halfwords and shifts the buffer down.
//   - instr_pc <= instr_pc + instr_size.
//   - Same-cycle fetch + output: cnt_next = cnt - consumed + appended. Max cnt is 4, never overflows.
//  FSM (2 states)
//   - RUN: normal operation.
//   - SKIP: next accepted fetch word's low halfword is dropped (halfword-aligned target).
//     SKIP -> RUN on the first fetch handshake.
//     flush with flush_pc[1]=1 -> SKIP; flush with flush_pc[1]=0 -> RUN.
//  Flush
//   - Cycle of flush: cnt <= 0, instr_pc <= {flush_pc[PC_W-1:1], 1'b0}, state per flush_pc[1].
//   - A fetch word presented during flush is not accepted (fetch_ready=0).
//   - instr_valid is not suppressed combinationally in the flush cycle. Any output handshake in
//     that cycle is ignored by the aligner; downstream treats it as squashed.
//   - flush has priority over all other updates.
//  Reset (async, active-high)
//   - cnt=0; instr_pc=RESET_PC; state = RESET_PC[1] ? SKIP : RUN.
//   - Buffer contents are don't-care.
//   - Outputs during reset: fetch_ready=1, instr_valid=0, instr_data=0, instr_size=4,
//     instr_pc=RESET_PC.
//   - Reset mid-operation drops all buffered halfwords; no partial instruction is emitted afterward.
//  Boundaries
//   - cnt=1 with 32-bit low half: instr_valid=0, waits for the next word.
//   - cnt=3 or 4: fetch_ready=0 even if a compressed output is consumed this cycle (no comb path).
//   - PC wraps modulo 2^PC_W.
// TESTING
//  T1:
//   Stimulus: words 0x00A00093, 0x00108113, instr_ready=1, RESET_PC=0.
//   Required: 2 instrs, size 4, pc 0x0 then 0x4.
//  T2:
//   Stimulus: word 0x00930505 (c.addi at [15:0], first half of a 32-bit instr at [31:16]),
//   then 0x0513_0000.
//   Required: c.addi size 2 @0x0, then 32-bit {0x0000,0x0093} @0x2; cnt returns to 1.
//  T3:
//   Stimulus: flush with flush_pc=0x102, then word 0x4505_DEAD.
//   Required: 0xDEAD is dropped; instr 0x00004505 size 2 @0x102.
//  T4:
//   Stimulus: 4 compressed halfwords fed in 2 words with instr_ready=0 for 5 cycles.
//   Required: cnt=4, fetch_ready=0, instr_data stable; then 4 outputs at pc 0,2,4,6.
//  T5:
//   Stimulus: rst asserted while cnt=3 and mid-handshake.
//   Required: instr_valid=0 immediately; after release the first instr is at RESET_PC.
//  T6:
//   Stimulus: flush asserted while fetch_valid=1 and instr_valid=1.
//   Required: fetch word not accepted, cnt=0 next cycle, instr_pc=flush_pc.

Source files
------------

// File: rtl/fetch_aligner.sv
// Fetch aligner: turns a stream of word-aligned 32-bit fetch words into whole
// RVC (16-bit) or 32-bit instructions, each tagged with its PC and byte size.
module fetch_aligner #(
    parameter int unsigned      PC_W     = 32,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [31:0]     fetch_data,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_data,
    output logic [2:0]      instr_size,
    output logic [PC_W-1:0] instr_pc
);

    // StSkip: the next accepted word's low halfword lies before the target PC.
    typedef enum logic {StRun, StSkip} state_t;

    localparam state_t RESET_STATE = RESET_PC[1] ? StSkip : StRun;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [15:0]     hw_q [4];
    logic [15:0]     hw_d [4];
    logic [PC_W-1:0] pc_q, pc_d;

    logic            compressed;
    logic            out_fire;
    logic            fetch_fire;
    logic [2:0]      consumed;
    logic [2:0]      appended;
    logic [2:0]      base;
    logic [PC_W-1:0] flush_target;

    // Output decode straight from registered state; nothing depends on instr_ready.
    always_comb begin
        compressed  = hw_q[0][1:0] != 2'b11;
        instr_valid = ((cnt_q >= 3'd1) && compressed) || (cnt_q >= 3'd2);
        fetch_ready = (cnt_q <= 3'd2) && !flush;
        instr_pc    = pc_q;
        instr_size  = (instr_valid && compressed) ? 3'd2 : 3'd4;
        instr_data  = '0;
        if (instr_valid) begin
            instr_data = compressed ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
        end
    end

    // Next state: shift out consumed halfwords, then append the fetch word behind them.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hw_d         = hw_q;
        appended     = 3'd0;
        out_fire     = instr_valid && instr_ready;
        fetch_fire   = fetch_valid && fetch_ready;
        consumed     = out_fire ? (compressed ? 3'd1 : 3'd2) : 3'd0;
        base         = cnt_q - consumed;
        // Bit 0 of the redirect target is forced low.
        flush_target = flush_pc & ~{{(PC_W-1){1'b0}}, 1'b1};

        unique case (consumed)
            3'd1: begin
                hw_d[0] = hw_q[1];
                hw_d[1] = hw_q[2];
                hw_d[2] = hw_q[3];
            end
            3'd2: begin
                hw_d[0] = hw_q[2];
                hw_d[1] = hw_q[3];
            end
            default: ;
        endcase

        if (out_fire) begin
            pc_d = pc_q + {{(PC_W-3){1'b0}}, instr_size};
        end

        // fetch_ready guarantees base <= 2, so base+1 stays inside the buffer.
        if (fetch_fire) begin
            if (state_q == StSkip) begin
                hw_d[base[1:0]] = fetch_data[31:16];
                appended        = 3'd1;
                state_d         = StRun;
            end else begin
                hw_d[base[1:0]]        = fetch_data[15:0];
                hw_d[base[1:0] + 2'd1] = fetch_data[31:16];
                appended               = 3'd2;
            end
        end

        cnt_d = base + appended;

        // Redirect overrides everything, including a same-cycle output handshake.
        if (flush) begin
            cnt_d   = 3'd0;
            pc_d    = flush_target;
            state_d = flush_pc[1] ? StSkip : StRun;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= 3'd0;
            pc_q    <= RESET_PC;
            for (int i = 0; i < 4; i++) begin
                hw_q[i] <= 16'h0000;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            for (int i = 0; i < 4; i++) begin
                hw_q[i] <= hw_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: halfword-queue model checked every cycle,
// plus directed scenarios with hand-computed instruction logs.
module tb_fetch_aligner;

    localparam int unsigned     PC_W     = 32;
    localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            fetch_valid = 1'b0;
    logic            fetch_ready;
    logic [31:0]     fetch_data = '0;
    logic            flush = 1'b0;
    logic [PC_W-1:0] flush_pc = '0;
    logic            instr_valid;
    logic            instr_ready = 1'b0;
    logic [31:0]     instr_data;
    logic [2:0]      instr_size;
    logic [PC_W-1:0] instr_pc;

    int tests = 0;
    int fails = 0;

    // Model state: queue of buffered halfwords, next PC, pending skip.
    logic [15:0] hq[$];
    logic [31:0] mpc;
    bit          mskip;

    // Log of accepted instructions as seen at the DUT outputs.
    logic [31:0] lq_d[$];
    logic [31:0] lq_p[$];
    logic [31:0] lq_s[$];

    fetch_aligner #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_data  (fetch_data),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_size  (instr_size),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare against the model mid-cycle, then advance the model to the next cycle.
    always @(negedge clk) begin
        logic        ev;
        logic        comp;
        logic [1:0]  nsz;
        if (rst) begin
            chk("rst_valid", {31'b0, instr_valid}, 32'd0);
            chk("rst_fready", {31'b0, fetch_ready}, 32'd1);
            chk("rst_data", instr_data, 32'd0);
            chk("rst_size", {29'b0, instr_size}, 32'd4);
            chk("rst_pc", instr_pc, RESET_PC);
            hq.delete();
            mpc   = RESET_PC;
            mskip = RESET_PC[1];
        end else begin
            comp = (hq.size() >= 1) && (hq[0][1:0] != 2'b11);
            ev   = comp || (hq.size() >= 2);
            chk("valid", {31'b0, instr_valid}, {31'b0, ev});
            chk("fready", {31'b0, fetch_ready}, {31'b0, (hq.size() <= 2) && !flush});
            if (ev) begin
                chk("data", instr_data, comp ? {16'h0, hq[0]} : {hq[1], hq[0]});
                chk("size", {29'b0, instr_size}, comp ? 32'd2 : 32'd4);
                chk("pc", instr_pc, mpc);
            end
            if (flush) begin
                hq.delete();
                mpc   = {flush_pc[31:1], 1'b0};
                mskip = flush_pc[1];
            end else begin
                if (ev && instr_ready) begin
                    lq_d.push_back(instr_data);
                    lq_p.push_back(instr_pc);
                    lq_s.push_back({29'b0, instr_size});
                    nsz = comp ? 2'd1 : 2'd2;
                    repeat (nsz) void'(hq.pop_front());
                    mpc = mpc + (comp ? 32'd2 : 32'd4);
                end
                if (fetch_valid && hq.size() + (ev && instr_ready ? nsz : 0) <= 2) begin
                    if (mskip) begin
                        hq.push_back(fetch_data[31:16]);
                        mskip = 1'b0;
                    end else begin
                        hq.push_back(fetch_data[15:0]);
                        hq.push_back(fetch_data[31:16]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok = 1'b0;
        fetch_valid = 1'b1;
        fetch_data  = w;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (fetch_ready) ok = 1'b1;
            tick();
        end
        fetch_valid = 1'b0;
        if (!ok) chk("fetch_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_log();
        lq_d.delete();
        lq_p.delete();
        lq_s.delete();
    endtask

    task automatic chk_log(input int idx, input logic [31:0] d, input logic [31:0] p,
                           input logic [31:0] s);
        if (idx >= lq_d.size()) begin
            chk("log_missing", lq_d.size(), idx + 1);
        end else begin
            chk("log_data", lq_d[idx], d);
            chk("log_pc", lq_p[idx], p);
            chk("log_size", lq_s[idx], s);
        end
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush    = 1'b1;
        flush_pc = target;
        tick();
        flush    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: two 32-bit instructions
        clear_log();
        instr_ready = 1'b1;
        send_word(32'h00A0_0093);
        send_word(32'h0010_8113);
        repeat (4) tick();
        chk("t1_count", lq_d.size(), 32'd2);
        chk_log(0, 32'h00A0_0093, 32'h0, 32'd4);
        chk_log(1, 32'h0010_8113, 32'h4, 32'd4);

        // T2: compressed then straddling 32-bit
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_log();
        send_word(32'h0093_0505);
        send_word(32'h0513_0000);
        repeat (4) tick();
        chk("t2_count", lq_d.size(), 32'd2);
        chk_log(0, 32'h0000_0505, 32'h0, 32'd2);
        chk_log(1, 32'h0000_0093, 32'h2, 32'd4);
        chk("t2_wait_valid", {31'b0, instr_valid}, 32'd0);
        chk("t2_wait_fready", {31'b0, fetch_ready}, 32'd1);

        // T3: halfword-aligned target drops the low halfword
        clear_log();
        do_flush(32'h0000_0102);
        send_word(32'h4505_DEAD);
        repeat (3) tick();
        chk("t3_count", lq_d.size(), 32'd1);
        chk_log(0, 32'h0000_4505, 32'h102, 32'd2);

        // T4: fill to 4 with downstream stalled, then drain
        clear_log();
        instr_ready = 1'b0;
        do_flush(32'h0);
        send_word(32'h0005_0001);
        send_word(32'h000D_0009);
        fetch_valid = 1'b1;
        fetch_data  = 32'h0015_0011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_fready", {31'b0, fetch_ready}, 32'd0);
            chk("t4_data", instr_data, 32'h0000_0001);
            tick();
        end
        instr_ready = 1'b1;
        send_word(32'h0015_0011);
        repeat (6) tick();
        chk("t4_count", lq_d.size(), 32'd6);
        chk_log(0, 32'h1, 32'h0, 32'd2);
        chk_log(1, 32'h5, 32'h2, 32'd2);
        chk_log(2, 32'h9, 32'h4, 32'd2);
        chk_log(3, 32'hD, 32'h6, 32'd2);
        chk_log(4, 32'h11, 32'h8, 32'd2);
        chk_log(5, 32'h15, 32'hA, 32'd2);

        // T5: reset with cnt=3 and an output handshake in progress
        rst = 1'b1;
        tick();
        rst = 1'b0;
        instr_ready = 1'b0;
        send_word(32'h0005_0001);
        instr_ready = 1'b1;
        send_word(32'h000D_0009);
        chk("t5_pre_valid", {31'b0, instr_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("t5_rst_pc", instr_pc, RESET_PC);
        tick();
        rst = 1'b0;
        clear_log();
        send_word(32'h00A0_0093);
        repeat (3) tick();
        chk("t5_count", lq_d.size(), 32'd1);
        chk_log(0, 32'h00A0_0093, RESET_PC, 32'd4);

        // T6: flush while a fetch word and an output are both offered
        instr_ready = 1'b0;
        send_word(32'h0005_0001);
        clear_log();
        fetch_valid = 1'b1;
        fetch_data  = 32'h1234_5679;
        instr_ready = 1'b1;
        flush       = 1'b1;
        flush_pc    = 32'h0000_0201;
        #1;
        chk("t6_fready", {31'b0, fetch_ready}, 32'd0);
        chk("t6_valid_kept", {31'b0, instr_valid}, 32'd1);
        tick();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        #1;
        chk("t6_valid_after", {31'b0, instr_valid}, 32'd0);
        chk("t6_pc_after", instr_pc, 32'h0000_0200);
        tick();
        chk("t6_no_log", lq_d.size(), 32'd0);

        // T7: PC wraps modulo 2^32
        clear_log();
        do_flush(32'hFFFF_FFFC);
        send_word(32'h00A0_0093);
        send_word(32'h0005_0001);
        repeat (4) tick();
        chk("t7_count", lq_d.size(), 32'd3);
        chk_log(0, 32'h00A0_0093, 32'hFFFF_FFFC, 32'd4);
        chk_log(1, 32'h1, 32'h0, 32'd2);
        chk_log(2, 32'h5, 32'h2, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
